// File: rtl/shift_add_multiplier_pkg.sv
// Shared constants for the shift-add multiplier: FSM state encodings and default operand width.
package shift_add_multiplier_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ADD   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Iteration counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/shift_add_multiplier_mult_ctrl_fsm.sv
// Sequencer for the shift-add multiplier: walks LOAD/ADD/SHIFT per multiplier bit and
// produces datapath strobes plus registered busy/done.
module mult_ctrl_fsm
  import shift_add_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic load_en_c,
  output logic add_en_c,
  output logic shift_en_c,
  output logic busy,
  output logic done
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_c;
  logic            busy_d, done_d;

  assign last_c = (cnt_q == CW'(WIDTH - 1));

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state, strobe decode, and next values of the registered status outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_en_c  = 1'b0;
    add_en_c   = 1'b0;
    shift_en_c = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        load_en_c = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ADD;
      end
      ST_ADD: begin
        add_en_c = 1'b1;
        state_d  = ST_SHIFT;
      end
      ST_SHIFT: begin
        shift_en_c = 1'b1;
        if (last_c) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = ST_ADD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_LOAD) || (state_d == ST_ADD) || (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per ADD/SHIFT pair,
// full 2*WIDTH product presented with a one-cycle done pulse.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic             load_en_c, add_en_c, shift_en_c;
  logic [WIDTH-1:0] m_q, q_q;
  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] sum_c;
  logic             carry_out_c;
  logic             carry;
  logic [WIDTH:0]   acc_shift_c;
  logic [WIDTH-1:0] q_shift_c;

  mult_ctrl_fsm #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load_en_c  (load_en_c),
    .add_en_c   (add_en_c),
    .shift_en_c (shift_en_c),
    .busy       (busy),
    .done       (done)
  );

  // Ripple of full-adder cells: m + acc[WIDTH-1:0], carry-out feeds acc[WIDTH].
  always_comb begin
    sum_c = '0;
    carry = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum_c[i] = m_q[i] ^ acc_q[i] ^ carry;
      carry    = (m_q[i] & acc_q[i]) | (carry & (m_q[i] ^ acc_q[i]));
    end
    carry_out_c = carry;
  end

  // Logical right shift of the {acc, q} concatenation.
  assign acc_shift_c = {1'b0, acc_q[WIDTH:1]};
  assign q_shift_c   = {acc_q[0], q_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q   <= '0;
      q_q   <= '0;
      acc_q <= '0;
    end else if (load_en_c) begin
      m_q   <= a;
      q_q   <= b;
      acc_q <= '0;
    end else if (add_en_c) begin
      if (q_q[0]) acc_q <= {carry_out_c, sum_c};
    end else if (shift_en_c) begin
      acc_q <= acc_shift_c;
      q_q   <= q_shift_c;
    end
  end

  assign product = {acc_q[WIDTH-1:0], q_q};

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential unsigned shift-add multiplier built on the logic-cell datapath. The block includes an internal FSM that sequences a ripple adder made from FullAdder cells and a set of accumulator and shift registers. It accepts one operand pair per start pulse, iterates one multiplier bit at a time, and raises a one-cycle done pulse when the full-width product is valid. It is the first block in the design that uses the cell library for multi-cycle arithmetic rather than single-cycle logic.

## Interface
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits; legal range 2..16
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  multiplicand, captured at LOAD
- b  input  WIDTH  multiplier, captured at LOAD
- busy  output  1  high in LOAD, ADD and SHIFT
- done  output  1  one-cycle pulse in the DONE state
- product  output  2*WIDTH  {acc[WIDTH-1:0], q}; valid while done is high; held until the next LOAD

## Operation
- Registers:
  - m: WIDTH bits, multiplicand
  - q: WIDTH bits, multiplier / low product
  - acc: WIDTH+1 bits, carry plus high product
  - cnt: counts 0..WIDTH-1
- FSM states and transitions:
  - IDLE -> LOAD when start=1; otherwise stay in IDLE.
  - LOAD: m<=a, q<=b, acc<=0, cnt<=0; -> ADD.
  - ADD: if q[0]=1, acc<=m+acc[WIDTH-1:0] (carry-out into acc[WIDTH]); else acc is held; -> SHIFT.
  - SHIFT: {acc,q}<={1'b0,acc,q[WIDTH-1:1]}, i.e. a logical right shift by 1 of the 2*WIDTH+1 concatenation. Then:
    - if cnt==WIDTH-1 -> DONE;
    - else cnt<=cnt+1 and -> ADD.
  - DONE: done=1; -> IDLE unconditionally.
- Arithmetic:
  - Unsigned only.
  - The adder is WIDTH bits wide and its carry-out lands in acc[WIDTH]; no overflow is possible.
  - After the final SHIFT, acc[WIDTH]=0.
- start handling:
  - start is ignored in LOAD, ADD, SHIFT and DONE; there is no queuing.
  - start held high continuously produces back-to-back operations: DONE -> IDLE -> LOAD.
- Input capture:
  - a and b are sampled only at the edge that leaves LOAD.
  - Changes to a and b at any other time have no effect.
- product:
  - Between LOAD and DONE, product shows intermediate values and is not valid.
  - In DONE and the following IDLE cycles, product is stable.
- Reset (asserted at any time, including mid-operation):
  - FSM goes to IDLE; m, q, acc and cnt clear to 0.
  - busy=0, done=0, product=0.
  - No partial result is retained.
  - The first start after reset deassertion is honoured normally.

## Timing
- E0 is the edge that samples start=1 in IDLE.
- State sequence:
  - LOAD after E0.
  - ADD of iteration i after edge E(1+2i).
  - SHIFT of iteration i after edge E(2+2i).
  - DONE after E(2*WIDTH+1).
- Latency:
  - done is high for exactly one cycle, 2*WIDTH+1 cycles after E0 (9 cycles for WIDTH=4).
  - busy rises after E0 and falls at the same edge that raises done.
- Throughput: the next start can be sampled at the first IDLE cycle after DONE, so the minimum period is 2*WIDTH+3 cycles.
- All outputs are registered-state decodes; no combinational path from start to any output.
- The adder is a combinational ripple of WIDTH FullAdder cells, settled within one cycle.

## Structure
- Shared constants header (project-wide include): FSM state encodings IDLE, LOAD, ADD, SHIFT, DONE (3-bit binary) and the default WIDTH.
- Sub-module mult_ctrl_fsm: state register, cnt, and decode of the load_en, add_en, shift_en, busy and done strobes. It takes the last-iteration flag from cnt compare.
- Datapath in the top level:
  - m/q/acc register banks built from Reg cells with load enables driven by the FSM strobes;
  - WIDTH-bit ripple adder instantiating FullAdder per bit;
  - shift muxes from Mux2_1_1.
- cnt width: clog2(WIDTH); the counter lives in the FSM.

## Test plan
- WIDTH=4, a=3, b=5, single start pulse -> done high exactly 9 cycles after the sampling edge, product=15, busy low in the same cycle.
- a=15, b=15 -> product=225 (8'hE1); acc carry used on the final iterations; a=0, b=9 -> product=0 and done timing unchanged.
- start pulsed again 3 cycles after E0, and a/b changed mid-operation -> ignored; product reflects the original operands; exactly one done pulse.
- start held high for 30 cycles with a=7, b=1 -> done pulses every 11 cycles (2*4+3); each product=7.
- rst driven low during the 2nd SHIFT of a=9, b=6 -> immediately busy=0, done=0, product=0. Restart with a=2, b=6 after release -> product=12 with the nominal 9-cycle latency.
- WIDTH=8, a=200, b=150 -> product=30000; done 17 cycles after the sampling edge.
